// File: rtl/exe_stage_pkg.sv
// Shared constants for the EX stage: bus widths, bus field offsets and ALU op bit indices.
package exe_stage_pkg;

  localparam int DS_BUS_W_DFLT = 117;
  localparam int ES_BUS_W_DFLT = 71;

  // ID->EX bus field offsets
  localparam int DS_RF_WE     = 116;
  localparam int DS_DEST_LSB  = 111;
  localparam int DS_RES_MEM   = 110;
  localparam int DS_SRC1_LSB  = 78;
  localparam int DS_SRC2_LSB  = 46;
  localparam int DS_OP_LSB    = 34;
  localparam int DS_MEM_WE    = 33;
  localparam int DS_MEM_EN    = 32;
  localparam int DS_PC_LSB    = 0;

  // EX->MEM bus field offsets
  localparam int ES_RES_MEM   = 70;
  localparam int ES_RF_WE     = 69;
  localparam int ES_DEST_LSB  = 64;
  localparam int ES_RES_LSB   = 32;
  localparam int ES_PC_LSB    = 0;

  // One-hot alu_op bit indices
  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LU12I = 11;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational 32-bit ALU with one-hot op select; multi-hot ORs the selected results.
module alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic signed [31:0] w_s1;
  logic signed [31:0] w_s2;
  logic        [4:0]  w_shamt;
  logic        [31:0] w_add;
  logic        [31:0] w_sub;
  logic        [31:0] w_sra;

  assign w_s1    = alu_src1;
  assign w_s2    = alu_src2;
  assign w_shamt = alu_src2[4:0];
  assign w_add   = alu_src1 + alu_src2;
  assign w_sub   = alu_src1 - alu_src2;
  assign w_sra   = w_s1 >>> w_shamt;

  always_comb begin
    alu_result = '0;
    if (alu_op[OP_ADD])   alu_result = alu_result | w_add;
    if (alu_op[OP_SUB])   alu_result = alu_result | w_sub;
    if (alu_op[OP_SLT])   alu_result = alu_result | {31'd0, (w_s1 < w_s2)};
    if (alu_op[OP_SLTU])  alu_result = alu_result | {31'd0, (alu_src1 < alu_src2)};
    if (alu_op[OP_AND])   alu_result = alu_result | (alu_src1 & alu_src2);
    if (alu_op[OP_NOR])   alu_result = alu_result | ~(alu_src1 | alu_src2);
    if (alu_op[OP_OR])    alu_result = alu_result | (alu_src1 | alu_src2);
    if (alu_op[OP_XOR])   alu_result = alu_result | (alu_src1 ^ alu_src2);
    if (alu_op[OP_SLL])   alu_result = alu_result | (alu_src1 << w_shamt);
    if (alu_op[OP_SRL])   alu_result = alu_result | (alu_src1 >> w_shamt);
    if (alu_op[OP_SRA])   alu_result = alu_result | w_sra;
    if (alu_op[OP_LU12I]) alu_result = alu_result | alu_src2;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: holds one instruction, runs the ALU, drives data RAM requests and the EX->MEM bus.
// Optional macro EX_ALIGN_CHK_EN suppresses data RAM requests to non-word-aligned addresses.
module exe_stage #(
  parameter int DS_BUS_W = exe_stage_pkg::DS_BUS_W_DFLT,
  parameter int ES_BUS_W = exe_stage_pkg::ES_BUS_W_DFLT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_2,
  output logic                allow_3,
  output logic                valid_3,
  input  logic                allow_4,
  input  logic [DS_BUS_W-1:0] stage_2_to_3,
  input  logic [31:0]         memory_write_data,
  output logic [ES_BUS_W-1:0] stage_3_to_4,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  output logic [4:0]          rf_waddr_3_fwd
);
  import exe_stage_pkg::*;

  logic                r_valid_3;
  logic [DS_BUS_W-1:0] r_bus;
  logic [31:0]         r_st_data;

  logic        w_rf_we;
  logic [4:0]  w_dest;
  logic        w_res_mem;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [11:0] w_op;
  logic        w_mem_we;
  logic        w_mem_en;
  logic [31:0] w_pc;
  logic [31:0] w_alu_result;
  logic        w_issue;
  logic        w_align_ok;

  // readygo is constant 1, so EX frees up whenever MEM takes its instruction
  assign allow_3 = ~r_valid_3 | allow_4;
  assign valid_3 = r_valid_3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_3 <= 1'b0;
      r_bus     <= '0;
      r_st_data <= '0;
    end else begin
      if (allow_3) r_valid_3 <= valid_2;
      if (valid_2 && allow_3) begin
        r_bus     <= stage_2_to_3;
        r_st_data <= memory_write_data;
      end
    end
  end

  assign w_rf_we   = r_bus[DS_RF_WE];
  assign w_dest    = r_bus[DS_DEST_LSB +: 5];
  assign w_res_mem = r_bus[DS_RES_MEM];
  assign w_src1    = r_bus[DS_SRC1_LSB +: 32];
  assign w_src2    = r_bus[DS_SRC2_LSB +: 32];
  assign w_op      = r_bus[DS_OP_LSB +: 12];
  assign w_mem_we  = r_bus[DS_MEM_WE];
  assign w_mem_en  = r_bus[DS_MEM_EN];
  assign w_pc      = r_bus[DS_PC_LSB +: 32];

  alu u_alu (
    .alu_op     (w_op),
    .alu_src1   (w_src1),
    .alu_src2   (w_src2),
    .alu_result (w_alu_result)
  );

`ifdef EX_ALIGN_CHK_EN
  assign w_align_ok = (w_alu_result[1:0] == 2'b00);
`else
  assign w_align_ok = 1'b1;
`endif

  // A request leaves only on the cycle MEM accepts the instruction
  assign w_issue         = r_valid_3 & allow_4 & w_align_ok;
  assign data_sram_en    = w_mem_en & w_issue;
  assign data_sram_we    = {4{w_mem_we & w_issue}};
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = r_st_data;

  assign rf_waddr_3_fwd = (w_rf_we & r_valid_3) ? w_dest : 5'd0;

  assign stage_3_to_4 = {w_res_mem, w_rf_we, w_dest, w_alu_result, w_pc};

endmodule

// File: tb/tb_exe_stage.sv
// Directed, table-driven bench for exe_stage: ALU vectors, store, stall, forwarding and reset corners.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_2;
  logic         allow_3;
  logic         valid_3;
  logic         allow_4;
  logic [116:0] stage_2_to_3;
  logic [31:0]  memory_write_data;
  logic [70:0]  stage_3_to_4;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [4:0]   rf_waddr_3_fwd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk               (clk),
    .reset             (reset),
    .valid_2           (valid_2),
    .allow_3           (allow_3),
    .valid_3           (valid_3),
    .allow_4           (allow_4),
    .stage_2_to_3      (stage_2_to_3),
    .memory_write_data (memory_write_data),
    .stage_3_to_4      (stage_3_to_4),
    .data_sram_en      (data_sram_en),
    .data_sram_we      (data_sram_we),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .rf_waddr_3_fwd    (rf_waddr_3_fwd)
  );

  typedef struct {
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [116:0] mk_bus(input logic rf_we, input logic [4:0] dest,
                                          input logic rfm, input logic [31:0] s1,
                                          input logic [31:0] s2, input logic [11:0] op,
                                          input logic mwe, input logic men,
                                          input logic [31:0] pc);
    return {rf_we, dest, rfm, s1, s2, op, mwe, men, pc};
  endfunction

  function automatic logic [70:0] mk_es(input logic rfm, input logic rf_we,
                                        input logic [4:0] dest, input logic [31:0] res,
                                        input logic [31:0] pc);
    return {rfm, rf_we, dest, res, pc};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [70:0] es_hold;

  initial begin
    vecs[0]  = '{12'h001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000}; // add overflow wraps
    vecs[1]  = '{12'h002, 32'h00000005, 32'h00000007, 32'hFFFFFFFE}; // sub
    vecs[2]  = '{12'h004, 32'hFFFFFFFF, 32'h00000001, 32'h00000001}; // slt signed
    vecs[3]  = '{12'h008, 32'hFFFFFFFF, 32'h00000001, 32'h00000000}; // sltu
    vecs[4]  = '{12'h010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000}; // and
    vecs[5]  = '{12'h020, 32'h0F0F0000, 32'h00000F0F, 32'hF0F0F0F0}; // nor
    vecs[6]  = '{12'h040, 32'h12340000, 32'h00005678, 32'h12345678}; // or
    vecs[7]  = '{12'h080, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F}; // xor
    vecs[8]  = '{12'h100, 32'h00000001, 32'h0000003F, 32'h80000000}; // sll, shamt from [4:0]
    vecs[9]  = '{12'h200, 32'h80000000, 32'h00000004, 32'h08000000}; // srl
    vecs[10] = '{12'h400, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF}; // sra
    vecs[11] = '{12'h800, 32'h12345678, 32'hABCDE000, 32'hABCDE000}; // lu12i
    vecs[12] = '{12'h000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000}; // no op
    vecs[13] = '{12'h050, 32'h0000000F, 32'h000000F0, 32'h000000FF}; // and|or multi-hot

    reset = 1'b1; valid_2 = 1'b0; allow_4 = 1'b0;
    stage_2_to_3 = '0; memory_write_data = '0;
    tick(); tick();
    chk("rst_valid_3", valid_3, 1'b0);
    chk("rst_allow_3", allow_3, 1'b1);
    chk("rst_en", data_sram_en, 1'b0);
    chk("rst_we", data_sram_we, 4'h0);
    chk("rst_fwd", rf_waddr_3_fwd, 5'd0);
    chk("rst_es_bus", stage_3_to_4, 71'd0);
    reset = 1'b0;
    tick();

    // Back-to-back ALU vectors: each cycle replaces EX contents with no bubble
    allow_4 = 1'b1;
    for (int i = 0; i < 14; i++) begin
      valid_2 = 1'b1;
      stage_2_to_3 = mk_bus(1'b1, 5'(i + 1), i[0], vecs[i].s1, vecs[i].s2, vecs[i].op,
                            1'b0, 1'b0, 32'h1C000000 + 32'(i * 4));
      tick();
      chk($sformatf("alu_vec%0d_bus", i), stage_3_to_4,
          mk_es(i[0], 1'b1, 5'(i + 1), vecs[i].res, 32'h1C000000 + 32'(i * 4)));
      chk($sformatf("alu_vec%0d_fwd", i), rf_waddr_3_fwd, 5'(i + 1));
    end
    chk("flow_valid_3", valid_3, 1'b1);
    chk("flow_en_no_mem", data_sram_en, 1'b0);
    valid_2 = 1'b0;
    tick();
    chk("drain_valid_3", valid_3, 1'b0);
    chk("drain_fwd", rf_waddr_3_fwd, 5'd0);

    // Store
    valid_2 = 1'b1;
    stage_2_to_3 = mk_bus(1'b0, 5'd0, 1'b0, 32'h1000, 32'h8, 12'h001, 1'b1, 1'b1, 32'h1C000100);
    memory_write_data = 32'hDEADBEEF;
    tick();
    valid_2 = 1'b0;
    chk("st_en", data_sram_en, 1'b1);
    chk("st_we", data_sram_we, 4'hF);
    chk("st_addr", data_sram_addr, 32'h1008);
    chk("st_wdata", data_sram_wdata, 32'hDEADBEEF);
    tick();
    chk("st_done_en", data_sram_en, 1'b0);

    // Load: request enable without byte writes
    valid_2 = 1'b1;
    stage_2_to_3 = mk_bus(1'b1, 5'd9, 1'b1, 32'h2000, 32'h4, 12'h001, 1'b0, 1'b1, 32'h1C000104);
    tick();
    valid_2 = 1'b0;
    chk("ld_en", data_sram_en, 1'b1);
    chk("ld_we", data_sram_we, 4'h0);
    chk("ld_bus", stage_3_to_4, mk_es(1'b1, 1'b1, 5'd9, 32'h2004, 32'h1C000104));
    tick();

    // Stall: MEM blocks for 3 cycles while ID offers a different instruction
    valid_2 = 1'b1; allow_4 = 1'b0;
    stage_2_to_3 = mk_bus(1'b0, 5'd0, 1'b0, 32'h1000, 32'h8, 12'h001, 1'b1, 1'b1, 32'h1C000200);
    memory_write_data = 32'hCAFEF00D;
    tick();
    es_hold = mk_es(1'b0, 1'b0, 5'd0, 32'h1008, 32'h1C000200);
    stage_2_to_3 = mk_bus(1'b1, 5'd3, 1'b0, 32'h5, 32'h5, 12'h001, 1'b0, 0, 32'h1C000204);
    memory_write_data = 32'h11111111;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d_allow_3", c), allow_3, 1'b0);
      chk($sformatf("stall%0d_en", c), data_sram_en, 1'b0);
      chk($sformatf("stall%0d_bus", c), stage_3_to_4, es_hold);
      chk($sformatf("stall%0d_wdata", c), data_sram_wdata, 32'hCAFEF00D);
      tick();
    end
    valid_2 = 1'b0; allow_4 = 1'b1;
    #1;
    chk("release_en", data_sram_en, 1'b1);
    chk("release_we", data_sram_we, 4'hF);
    chk("release_allow_3", allow_3, 1'b1);
    tick();
    chk("release_once_en", data_sram_en, 1'b0);
    chk("release_valid_3", valid_3, 1'b0);

    // Forwarding gated by rf_we
    valid_2 = 1'b1;
    stage_2_to_3 = mk_bus(1'b0, 5'd5, 1'b0, 32'h1, 32'h1, 12'h001, 1'b0, 1'b0, 32'h1C000300);
    tick();
    chk("fwd_no_rfwe", rf_waddr_3_fwd, 5'd0);
    stage_2_to_3 = mk_bus(1'b1, 5'd5, 1'b0, 32'h1, 32'h1, 12'h001, 1'b0, 1'b0, 32'h1C000304);
    tick();
    valid_2 = 1'b0;
    chk("fwd_dest5", rf_waddr_3_fwd, 5'd5);
    tick();

    // Reset during a stall drops the held store
    valid_2 = 1'b1; allow_4 = 1'b0;
    stage_2_to_3 = mk_bus(1'b1, 5'd7, 1'b0, 32'h1000, 32'h8, 12'h001, 1'b1, 1'b1, 32'h1C000400);
    memory_write_data = 32'h12345678;
    tick();
    valid_2 = 1'b0;
    chk("pre_rst_fwd", rf_waddr_3_fwd, 5'd7);
    reset = 1'b1;
    tick();
    chk("midrst_valid_3", valid_3, 1'b0);
    chk("midrst_allow_3", allow_3, 1'b1);
    chk("midrst_fwd", rf_waddr_3_fwd, 5'd0);
    chk("midrst_wdata", data_sram_wdata, 32'h0);
    reset = 1'b0; allow_4 = 1'b1;
    #1;
    chk("midrst_en", data_sram_en, 1'b0);
    chk("midrst_we", data_sram_we, 4'h0);
    tick();
    chk("postrst_en", data_sram_en, 1'b0);

    // Misaligned store
    valid_2 = 1'b1;
    stage_2_to_3 = mk_bus(1'b0, 5'd0, 1'b0, 32'h1000, 32'h2, 12'h001, 1'b1, 1'b1, 32'h1C000500);
    memory_write_data = 32'hA5A5A5A5;
    tick();
    valid_2 = 1'b0;
`ifdef EX_ALIGN_CHK_EN
    chk("misalign_we", data_sram_we, 4'h0);
    chk("misalign_en", data_sram_en, 1'b0);
`else
    chk("misalign_we", data_sram_we, 4'hF);
    chk("misalign_en", data_sram_en, 1'b1);
`endif
    chk("misalign_bus", stage_3_to_4, mk_es(1'b0, 1'b0, 5'd0, 32'h1002, 32'h1C000500));
    chk("misalign_valid_3", valid_3, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: stage_3_ex

Interface
REQ-001 Parameter DS_BUS_W, default 117, SHALL set the width of the ID->EX bus.
REQ-002 Parameter ES_BUS_W, default 71, SHALL set the width of the EX->MEM bus.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 valid_2  input  1  ID holds a valid instruction.
REQ-006 allow_3  output  1  EX can accept an instruction this cycle.
REQ-007 valid_3  output  1  EX holds a valid instruction (registered).
REQ-008 allow_4  input  1  MEM can accept an instruction this cycle.
REQ-009 stage_2_to_3  input  DS_BUS_W  bus {rf_we[116], dest[115:111], res_from_mem[110], alu_src1[109:78], alu_src2[77:46], alu_op[45:34], mem_we[33], mem_en[32], pc[31:0]}.
REQ-010 memory_write_data  input  32  store data from ID.
REQ-011 stage_3_to_4  output  ES_BUS_W  bus {res_from_mem[70], rf_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-012 data_sram_en  output  1  data RAM request enable.
REQ-013 data_sram_we  output  4  data RAM byte write enables.
REQ-014 data_sram_addr  output  32  data RAM address.
REQ-015 data_sram_wdata  output  32  data RAM write data.
REQ-016 rf_waddr_3_fwd  output  5  EX destination, published to ID for hazard detection.

Function
REQ-017 readygo_3 SHALL be constant 1; allow_3 SHALL equal ~valid_3 | allow_4.
REQ-018 valid_3 SHALL load valid_2 when allow_3 is 1 and SHALL otherwise hold.
REQ-019 The bus register and the store-data register SHALL capture stage_2_to_3 and memory_write_data only when valid_2 & allow_3, and SHALL hold otherwise (MEM stall: contents frozen).
REQ-020 ALU (alu_op one-hot, bit order 0..11): add, sub, slt (signed), sltu, and, nor, or, xor, sll, srl, sra, lu12i (result = src2).
REQ-021 Shift amount SHALL be src2[4:0]; add/sub SHALL be 32-bit with carry-out discarded.
REQ-022 alu_op all-zero SHALL give alu_result 0; multi-hot SHALL give the OR of the selected results.
REQ-023 The ALU SHALL be purely combinational: result available in the same cycle the instruction is held (latency 1 cycle from capture to stage_3_to_4).
REQ-024 data_sram_en SHALL equal mem_en & valid_3 & allow_4; data_sram_we SHALL equal {4{mem_we & valid_3 & allow_4}}.
REQ-025 data_sram_addr SHALL equal alu_result; data_sram_wdata SHALL equal the registered store data.
REQ-026 rf_waddr_3_fwd SHALL equal dest when rf_we & valid_3, and 5'd0 otherwise.
REQ-027 stage_3_to_4 SHALL be driven combinationally from the held registers and alu_result, with no gating by valid_3.
REQ-028 A simultaneous pipeline advance (valid_3 & allow_4 & valid_2) SHALL replace EX contents in one cycle with no bubble.

Reset
REQ-029 While reset is 1, valid_3 and both data registers SHALL be 0.
REQ-030 Consequently, under reset: allow_3 SHALL be 1, data_sram_en and data_sram_we SHALL be 0, and rf_waddr_3_fwd SHALL be 0.
REQ-031 Reset asserted mid-stall SHALL discard the held instruction without issuing a memory request on the next cycle.

Configuration
REQ-032 Macro EX_ALIGN_CHK_EN SHALL, when defined, force data_sram_en and data_sram_we to 0 for a memory access whose data_sram_addr[1:0] != 0.
REQ-033 When EX_ALIGN_CHK_EN is defined, stage_3_to_4 SHALL still flow for that access.
REQ-034 Without EX_ALIGN_CHK_EN, no alignment check SHALL exist and REQ-024 SHALL apply unchanged.

Structure
REQ-035 The shared package SHALL hold the DS_BUS_W and ES_BUS_W constants, the bus field-offset constants and the alu_op bit-index constants.
REQ-036 The ALU SHALL be a separate sub-module named alu, with ports alu_op[11:0], alu_src1, alu_src2 and alu_result.

Verification
REQ-037 add: src1=0x7FFFFFFF, src2=1, alu_op[0]=1 -> alu_result 0x80000000 one cycle after capture.
REQ-038 slt/sltu: src1=0xFFFFFFFF, src2=1 -> slt gives 1 and sltu gives 0; sra of 0x80000000 by 31 -> 0xFFFFFFFF.
REQ-039 Store: mem_we=1, mem_en=1, src1=0x1000, src2=8, memory_write_data=0xDEADBEEF, allow_4=1 -> data_sram_we=0xF, data_sram_addr=0x1008, data_sram_wdata=0xDEADBEEF.
REQ-040 Stall: allow_4=0 for 3 cycles with valid_3=1 -> allow_3=0, data_sram_en=0 and bus held stable; on release the request is issued once.
REQ-041 Forwarding: rf_we=1, dest=5 -> rf_waddr_3_fwd=5; with rf_we=0 or valid_3=0 -> rf_waddr_3_fwd=0.
REQ-042 EX_ALIGN_CHK_EN defined, store to 0x1002 -> data_sram_we=0; the bus still reaches MEM.
